// File: rtl/decoder_n_scan_if.sv
// decoder_n_scan_if: control and status bundle for decoder_n_scan.
// The master side drives enable/mode/load/select/divisor and the slave side
// returns the registered one-hot select and its status flags.
// Defining DECODER_N_SCAN_ERR_EN adds the sticky error pair err_clr/err.
interface decoder_n_scan_if #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8,
    parameter int DIV_W   = 8
) ();
    logic               en;
    logic               mode;
    logic               load;
    logic [SEL_W-1:0]   sel;
    logic [DIV_W-1:0]   div;
    logic [NUM_OUT-1:0] out;
    logic [SEL_W-1:0]   idx;
    logic               valid;
    logic               wrap;
`ifdef DECODER_N_SCAN_ERR_EN
    logic               err_clr;
    logic               err;

    modport master (
        output en, mode, load, sel, div, err_clr,
        input  out, idx, valid, wrap, err
    );

    modport slave (
        input  en, mode, load, sel, div, err_clr,
        output out, idx, valid, wrap, err
    );
`else
    modport master (
        output en, mode, load, sel, div,
        input  out, idx, valid, wrap
    );

    modport slave (
        input  en, mode, load, sel, div,
        output out, idx, valid, wrap
    );
`endif
endinterface

// File: rtl/decoder_n_scan.sv
// decoder_n_scan: registered one-hot line driver with two modes.
//   mode=0: direct decode of a loaded select.
//   mode=1: auto-scan, a prescaled ring stepping idx through 0..NUM_OUT-1.
// Per-cycle priority: en=0 > load > scan step > hold.
// Status semantics: valid is high exactly when out holds a legal one-hot
// value; it is a level flag, not a handshake, and there is no back-pressure.
// wrap is a one-cycle pulse registered on the scan step NUM_OUT-1 -> 0.
// The first enabled edge after re-enable or a mode change only restores
// out=1<<idx and clears the prescaler; stepping starts on the next edge.
// Optional feature macro: DECODER_N_SCAN_ERR_EN (sticky out-of-range error).
module decoder_n_scan #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8,
    parameter int DIV_W   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    decoder_n_scan_if.slave bus
);
    localparam logic [SEL_W-1:0]   LAST_IDX = SEL_W'(NUM_OUT - 1);
    localparam logic [SEL_W:0]     LINES    = (SEL_W + 1)'(NUM_OUT);
    localparam logic [NUM_OUT-1:0] ONE      = NUM_OUT'(1);

    logic [NUM_OUT-1:0] out_q, out_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;
    logic [DIV_W-1:0]   pre_q, pre_d;
    logic               blank_q, blank_d;
    logic               mode_q;
    logic               sel_ok;
    logic               restart;

    // Select range check and "first edge after blank or mode change" flag.
    always_comb begin
        sel_ok  = ({1'b0, bus.sel} < LINES);
        restart = blank_q || (bus.mode != mode_q);
    end

    // Next-state selection following en=0 > load > step > hold.
    always_comb begin
        out_d   = out_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        pre_d   = pre_q;
        blank_d = blank_q;
        if (!bus.en) begin
            out_d   = '0;
            valid_d = 1'b0;
            pre_d   = '0;
            blank_d = 1'b1;
        end else if (!bus.mode) begin
            blank_d = 1'b0;
            pre_d   = '0;
            if (bus.load) begin
                if (sel_ok) begin
                    idx_d   = bus.sel;
                    out_d   = ONE << bus.sel;
                    valid_d = 1'b1;
                end else begin
                    out_d   = '0;
                    valid_d = 1'b0;
                end
            end else if (blank_q) begin
                out_d   = ONE << idx_q;
                valid_d = 1'b1;
            end
        end else begin
            blank_d = 1'b0;
            valid_d = 1'b1;
            if (bus.load && sel_ok) begin
                idx_d = bus.sel;
                pre_d = '0;
            end else if (restart) begin
                pre_d = '0;
            end else if (pre_q == bus.div) begin
                pre_d  = '0;
                idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + SEL_W'(1);
                wrap_d = (idx_q == LAST_IDX);
            end else begin
                pre_d = pre_q + DIV_W'(1);
            end
            out_d = ONE << idx_d;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            pre_q   <= '0;
            blank_q <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            out_q   <= out_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            pre_q   <= pre_d;
            blank_q <= blank_d;
            mode_q  <= bus.mode;
        end
    end

    assign bus.out   = out_q;
    assign bus.idx   = idx_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;

`ifdef DECODER_N_SCAN_ERR_EN
    logic err_q, err_d;

    // Sticky error: set by an enabled out-of-range load, clear has priority.
    always_comb begin
        err_d = err_q;
        if (bus.en && bus.load && !sel_ok) begin
            err_d = 1'b1;
        end
        if (bus.err_clr) begin
            err_d = 1'b0;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_decoder_n_scan.sv
// tb_decoder_n_scan: drives an 8-line and a 5-line decoder_n_scan with
// identical stimulus; directed scenarios check literal expectations and a
// randomized phase compares both against a line/index reference model.
// Honours DECODER_N_SCAN_ERR_EN when defined.
module tb_decoder_n_scan;
    localparam int SEL_W = 3;
    localparam int DIV_W = 8;

    logic clk = 1'b0;
    logic rst_n;

    // clock
    always #5 clk = ~clk;

    decoder_n_scan_if #(.SEL_W(SEL_W), .NUM_OUT(8), .DIV_W(DIV_W)) bus8 ();
    decoder_n_scan_if #(.SEL_W(SEL_W), .NUM_OUT(5), .DIV_W(DIV_W)) bus5 ();

    decoder_n_scan #(.SEL_W(SEL_W), .NUM_OUT(8), .DIV_W(DIV_W)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    decoder_n_scan #(.SEL_W(SEL_W), .NUM_OUT(5), .DIV_W(DIV_W)) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model, index 0 = 8-line instance, index 1 = 5-line instance.
    // m_line is the line shown on out, -1 when blank/invalid.
    int n_lines [2] = '{8, 5};
    int m_idx   [2];
    int m_line  [2];
    int m_pre   [2];
    bit m_wrap  [2];
    bit m_blank [2];
    bit m_pmode [2];
    bit m_err   [2];

    logic [31:0] o_out   [2];
    logic [31:0] o_idx   [2];
    logic        o_valid [2];
    logic        o_wrap  [2];
    logic        o_err   [2];

    function automatic logic [31:0] exp_out(input int k);
        return (m_line[k] < 0) ? 32'd0 : (32'd1 << m_line[k]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_idx[k]   = 0;
            m_line[k]  = -1;
            m_pre[k]   = 0;
            m_wrap[k]  = 1'b0;
            m_blank[k] = 1'b0;
            m_pmode[k] = 1'b0;
            m_err[k]   = 1'b0;
        end
    endtask

    task automatic model_update(input int k, input bit en, input bit mode, input bit load,
                                input int sel, input int div, input bit clr);
        bit ok;
        ok = (sel < n_lines[k]);
        m_wrap[k] = 1'b0;
        if (!en) begin
            m_line[k]  = -1;
            m_pre[k]   = 0;
            m_blank[k] = 1'b1;
        end else if (!mode) begin
            m_pre[k] = 0;
            if (load) begin
                if (ok) begin
                    m_idx[k]  = sel;
                    m_line[k] = sel;
                end else begin
                    m_line[k] = -1;
                end
            end else if (m_blank[k]) begin
                m_line[k] = m_idx[k];
            end
            m_blank[k] = 1'b0;
        end else begin
            if (load && ok) begin
                m_idx[k] = sel;
                m_pre[k] = 0;
            end else if (m_blank[k] || (mode != m_pmode[k])) begin
                m_pre[k] = 0;
            end else if (m_pre[k] == div) begin
                m_pre[k]  = 0;
                m_wrap[k] = (m_idx[k] == n_lines[k] - 1);
                m_idx[k]  = (m_idx[k] + 1) % n_lines[k];
            end else begin
                m_pre[k] = (m_pre[k] + 1) % (1 << DIV_W);
            end
            m_line[k]  = m_idx[k];
            m_blank[k] = 1'b0;
        end
        m_pmode[k] = mode;
        if (en && load && !ok) m_err[k] = 1'b1;
        if (clr) m_err[k] = 1'b0;
    endtask

    task automatic set_inputs(input bit en, input bit mode, input bit load,
                              input int sel, input int div, input bit clr);
        bus8.en   = en;
        bus8.mode = mode;
        bus8.load = load;
        bus8.sel  = SEL_W'(sel);
        bus8.div  = DIV_W'(div);
        bus5.en   = en;
        bus5.mode = mode;
        bus5.load = load;
        bus5.sel  = SEL_W'(sel);
        bus5.div  = DIV_W'(div);
`ifdef DECODER_N_SCAN_ERR_EN
        bus8.err_clr = clr;
        bus5.err_clr = clr;
`else
        if (clr) begin end
`endif
    endtask

    task automatic sample();
        o_out[0]   = 32'(bus8.out);
        o_out[1]   = 32'(bus5.out);
        o_idx[0]   = 32'(bus8.idx);
        o_idx[1]   = 32'(bus5.idx);
        o_valid[0] = bus8.valid;
        o_valid[1] = bus5.valid;
        o_wrap[0]  = bus8.wrap;
        o_wrap[1]  = bus5.wrap;
`ifdef DECODER_N_SCAN_ERR_EN
        o_err[0]   = bus8.err;
        o_err[1]   = bus5.err;
`else
        o_err[0]   = 1'b0;
        o_err[1]   = 1'b0;
`endif
    endtask

    // driver: apply inputs away from the edge, clock once, advance the model, sample
    task automatic step(input bit en, input bit mode, input bit load,
                        input int sel, input int div, input bit clr);
        set_inputs(en, mode, load, sel, div, clr);
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k, en, mode, load, sel, div, clr);
        #1;
        sample();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_inputs(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        sample();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_out[k] !== 32'd0 || o_idx[k] !== 32'd0 || o_valid[k] !== 1'b0 || o_wrap[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_state: dut%0d out=%0h idx=%0d valid=%b wrap=%b, want all 0",
                         k, o_out[k], o_idx[k], o_valid[k], o_wrap[k]);
            end
        end
        rst_n = 1'b1;
        step(1, 0, 1, 4, 0, 0);
        checks++;
        if (o_out[0] !== 32'h10) begin
            failures++;
            $display("FAIL pre_reset_out: got %0h want 10", o_out[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        sample();
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_out[k] !== 32'd0 || o_idx[k] !== 32'd0 || o_valid[k] !== 1'b0) begin
                failures++;
                $display("FAIL async_reset: dut%0d out=%0h idx=%0d valid=%b, want 0 0 0",
                         k, o_out[k], o_idx[k], o_valid[k]);
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_decode();
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1, i, 0, 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_out[k] !== (32'd1 << i) || o_valid[k] !== 1'b1 || o_idx[k] !== 32'(i)) begin
                    failures++;
                    $display("FAIL decode_sel%0d: dut%0d out=%0h idx=%0d valid=%b, want %0h %0d 1",
                             i, k, o_out[k], o_idx[k], o_valid[k], 32'd1 << i, i);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        step(1, 0, 1, 2, 0, 0);
        step(1, 0, 1, 6, 0, 0);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (o_out[1] !== 32'd0 || o_valid[1] !== 1'b0 || o_idx[1] !== 32'd2) begin
                failures++;
                $display("FAIL oor_decode5_c%0d: out=%0h idx=%0d valid=%b, want 0 2 0",
                         c, o_out[1], o_idx[1], o_valid[1]);
            end
            checks++;
            if (o_out[0] !== 32'h40 || o_valid[0] !== 1'b1 || o_idx[0] !== 32'd6) begin
                failures++;
                $display("FAIL inrange_decode8_c%0d: out=%0h idx=%0d valid=%b, want 40 6 1",
                         c, o_out[0], o_idx[0], o_valid[0]);
            end
`ifdef DECODER_N_SCAN_ERR_EN
            checks++;
            if (o_err[1] !== 1'b1 || o_err[0] !== 1'b0) begin
                failures++;
                $display("FAIL err_set_c%0d: err5=%b err8=%b, want 1 0", c, o_err[1], o_err[0]);
            end
`endif
            step(1, 0, 0, 0, 0, 0);
        end
`ifdef DECODER_N_SCAN_ERR_EN
        step(1, 0, 1, 7, 0, 1);
        checks++;
        if (o_err[1] !== 1'b0) begin
            failures++;
            $display("FAIL err_clear_wins: err5=%b want 0", o_err[1]);
        end
`endif
    endtask

    task automatic test_scan_wrap();
        step(1, 0, 1, 0, 2, 0);
        for (int c = 0; c < 18; c++) begin
            step(1, 1, 0, 0, 2, 0);
            checks++;
            if (o_out[1] !== (32'd1 << ((c / 3) % 5)) || o_wrap[1] !== (c == 15) || o_valid[1] !== 1'b1) begin
                failures++;
                $display("FAIL scan_div2_c%0d: out=%0h wrap=%b valid=%b, want %0h %b 1",
                         c, o_out[1], o_wrap[1], o_valid[1], 32'd1 << ((c / 3) % 5), c == 15);
            end
            checks++;
            if (o_out[0] !== (32'd1 << ((c / 3) % 8)) || o_wrap[0] !== 1'b0) begin
                failures++;
                $display("FAIL scan8_div2_c%0d: out=%0h wrap=%b, want %0h 0",
                         c, o_out[0], o_wrap[0], 32'd1 << ((c / 3) % 8));
            end
        end
        step(1, 1, 1, 0, 0, 0);
        for (int c = 1; c < 8; c++) begin
            step(1, 1, 0, 0, 0, 0);
            checks++;
            if (o_out[1] !== (32'd1 << (c % 5)) || o_wrap[1] !== (c == 5)) begin
                failures++;
                $display("FAIL scan_div0_c%0d: out=%0h wrap=%b, want %0h %b",
                         c, o_out[1], o_wrap[1], 32'd1 << (c % 5), c == 5);
            end
        end
    endtask

    task automatic test_load_scan();
        step(1, 1, 1, 1, 3, 0);
        step(1, 1, 0, 0, 3, 0);
        step(1, 1, 0, 0, 3, 0);
        step(1, 1, 1, 3, 3, 0);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) step(1, 1, 0, 0, 3, 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_out[k] !== ((c < 4) ? 32'h08 : 32'h10)) begin
                    failures++;
                    $display("FAIL load_scan_hold_c%0d: dut%0d out=%0h want %0h",
                             c, k, o_out[k], (c < 4) ? 32'h08 : 32'h10);
                end
            end
        end
        repeat (3) step(1, 1, 0, 0, 3, 0);
        step(1, 1, 1, 1, 3, 0);
        checks++;
        if (o_out[1] !== 32'h02 || o_wrap[1] !== 1'b0 || o_idx[1] !== 32'd1) begin
            failures++;
            $display("FAIL load_beats_step: out=%0h wrap=%b idx=%0d, want 2 0 1",
                     o_out[1], o_wrap[1], o_idx[1]);
        end
        step(1, 1, 1, 6, 3, 0);
        checks++;
        if (o_out[1] !== 32'h02 || o_idx[1] !== 32'd1 || o_out[0] !== 32'h40) begin
            failures++;
            $display("FAIL oor_scan_load: out5=%0h idx5=%0d out8=%0h, want 2 1 40",
                     o_out[1], o_idx[1], o_out[0]);
        end
    endtask

    task automatic test_blank();
        step(1, 1, 1, 2, 3, 0);
        step(1, 1, 0, 0, 3, 0);
        for (int c = 0; c < 4; c++) begin
            step(0, 1, 0, 0, 3, 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_out[k] !== 32'd0 || o_valid[k] !== 1'b0 || o_idx[k] !== 32'd2 || o_wrap[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL blank_c%0d: dut%0d out=%0h valid=%b idx=%0d wrap=%b, want 0 0 2 0",
                             c, k, o_out[k], o_valid[k], o_idx[k], o_wrap[k]);
                end
            end
        end
        for (int c = 0; c < 5; c++) begin
            step(1, 1, 0, 0, 3, 0);
            checks++;
            if (o_out[1] !== ((c < 4) ? 32'h04 : 32'h08) || o_valid[1] !== 1'b1) begin
                failures++;
                $display("FAIL reenable_c%0d: out=%0h valid=%b, want %0h 1",
                         c, o_out[1], o_valid[1], (c < 4) ? 32'h04 : 32'h08);
            end
        end
    endtask

    task automatic test_mode_switch();
        logic [31:0] want_out;
        step(1, 0, 1, 7, 1, 0);
        checks++;
        if (o_out[0] !== 32'h80 || o_out[1] !== 32'd0 || o_valid[1] !== 1'b0) begin
            failures++;
            $display("FAIL decode_sel7: out8=%0h out5=%0h valid5=%b, want 80 0 0",
                     o_out[0], o_out[1], o_valid[1]);
        end
        for (int c = 0; c < 4; c++) begin
            step(1, 1, 0, 0, 1, 0);
            want_out = (c < 2) ? 32'h80 : 32'h01;
            checks++;
            if (o_out[0] !== want_out || o_wrap[0] !== (c == 2)) begin
                failures++;
                $display("FAIL to_scan_c%0d: out=%0h wrap=%b, want %0h %b",
                         c, o_out[0], o_wrap[0], want_out, c == 2);
            end
        end
        for (int c = 0; c < 3; c++) begin
            step(1, 0, 0, 0, 1, 0);
            checks++;
            if (o_out[0] !== 32'h01 || o_wrap[0] !== 1'b0 || o_idx[0] !== 32'd0) begin
                failures++;
                $display("FAIL to_decode_hold_c%0d: out=%0h wrap=%b idx=%0d, want 1 0 0",
                         c, o_out[0], o_wrap[0], o_idx[0]);
            end
        end
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        checks++;
        if (o_out[0] !== 32'h01 || o_valid[0] !== 1'b1) begin
            failures++;
            $display("FAIL decode_reenable: out=%0h valid=%b, want 1 1", o_out[0], o_valid[0]);
        end
    endtask

    task automatic test_random();
        bit en, mode, load, clr;
        int sel, div;
        mode = 1'b0;
        div  = 1;
        for (int c = 0; c < 500; c++) begin
            en   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 11) == 0) mode = ~mode;
            if ($urandom_range(0, 19) == 0) div = $urandom_range(0, 3);
            load = ($urandom_range(0, 4) == 0);
            sel  = $urandom_range(0, 7);
            clr  = ($urandom_range(0, 7) == 0);
            step(en, mode, load, sel, div, clr);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_out[k] !== exp_out(k) || o_idx[k] !== 32'(m_idx[k]) ||
                    o_valid[k] !== (m_line[k] >= 0) || o_wrap[k] !== m_wrap[k]) begin
                    failures++;
                    $display("FAIL random_c%0d: dut%0d out=%0h idx=%0d valid=%b wrap=%b, want %0h %0d %b %b",
                             c, k, o_out[k], o_idx[k], o_valid[k], o_wrap[k],
                             exp_out(k), m_idx[k], m_line[k] >= 0, m_wrap[k]);
                end
                checks++;
                if ($countones(o_out[k]) > 1 || o_idx[k] >= 32'(n_lines[k])) begin
                    failures++;
                    $display("FAIL random_legal_c%0d: dut%0d out=%0h idx=%0d, want one-hot and idx<%0d",
                             c, k, o_out[k], o_idx[k], n_lines[k]);
                end
`ifdef DECODER_N_SCAN_ERR_EN
                checks++;
                if (o_err[k] !== m_err[k]) begin
                    failures++;
                    $display("FAIL random_err_c%0d: dut%0d err=%b want %b", c, k, o_err[k], m_err[k]);
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_out_of_range();
        test_scan_wrap();
        test_load_scan();
        test_blank();
        test_mode_switch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decoder_n_scan.md
Name: decoder_n_scan

Overview:
- Parametrised, registered successor to the combinational 2-to-4 decoder.
- Drives a one-hot output vector of NUM_OUT lines (NUM_OUT need not be a power of two). Uses one of two modes:
  - direct decode of a loaded select;
  - auto-scan, where a prescaled ring steps through the lines (display/row scanning).
- Sits between control logic and JK-flip-flop-based or LED/row-select loads that need glitch-free, registered selects.

Parameters:
- SEL_W, 3, width of the select/index.
- NUM_OUT, 8, number of output lines; legal range 2..2**SEL_W.
- DIV_W, 8, width of the runtime scan prescaler divisor.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active low.
- en  input  1  block enable; low blanks outputs.
- mode  input  1  0 = decode, 1 = scan.
- load  input  1  capture sel this cycle.
- sel  input  SEL_W  requested line index.
- div  input  DIV_W  scan mode advances once every div+1 enabled cycles.
- out  output  NUM_OUT  registered one-hot select.
- idx  output  SEL_W  index currently (or last) selected.
- valid  output  1  out holds a legal one-hot value.
- wrap  output  1  one-cycle pulse on scan wrap NUM_OUT-1 -> 0.

Behaviour:
- Reset (rst_n low, asynchronous): out=0, idx=0, valid=0, wrap=0, prescaler=0. The first valid state after release needs a load (decode) or en with mode=1 (scan).
- All state updates on rising clk. out, idx and valid are registered; latency from load/step to out is exactly 1 cycle.
- Priority per cycle: en=0 > load > scan step > hold.
- en=0:
  - next edge forces out=0, valid=0, wrap=0 and prescaler=0;
  - idx holds;
  - on re-enable, out shows 1<<idx one cycle later in either mode.
- Decode mode (mode=0):
  - load=1 with sel<NUM_OUT: idx<=sel, out<=1<<sel, valid<=1.
  - load=1 with sel>=NUM_OUT: out<=0, valid<=0, idx holds.
  - load=0: out/idx/valid hold.
  - Prescaler held at 0; wrap=0.
- Scan mode (mode=1):
  - out is always 1<<idx and valid=1 (one cycle after entering the mode or enabling).
  - Prescaler counts 0..div. On the cycle prescaler==div:
    - prescaler<=0;
    - idx<=(idx==NUM_OUT-1)?0:idx+1;
    - wrap<=1 only when idx was NUM_OUT-1.
  - Otherwise prescaler increments and wrap<=0.
  - div=0: advance every cycle.
  - div changed mid-count: compared against the new value on the next cycle. If the prescaler already exceeds the new div, it counts up to its maximum, wraps to 0, then reaches div normally.
- load in scan mode:
  - sel<NUM_OUT: idx<=sel, prescaler<=0, no wrap, stepping resumes from sel.
  - out-of-range sel: load ignored entirely.
- Mode change (mode toggles between cycles): prescaler cleared at the edge where the new mode is first sampled; idx retained.
- Non-power-of-two NUM_OUT: idx never exceeds NUM_OUT-1; out bits above NUM_OUT do not exist.
- out is never multi-hot in any cycle.

Optional Feature:
- Macro: DECODER_N_SCAN_ERR_EN.
- Defined:
  - adds input err_clr (1 bit) and output err (1 bit, reset 0);
  - err sets on any load with sel>=NUM_OUT in either mode, while en=1;
  - err stays set until an err_clr=1 cycle (clear wins over a simultaneous set) or reset.
- Undefined: ports absent; out-of-range loads behave exactly as in Behaviour with no indication.

Test Plan:
- Reset then decode: rst_n low mid-run with out=0x10 -> out=0, idx=0, valid=0 immediately. Release, mode=0, load sel=0,1,2,3 -> out=0x01,0x02,0x04,0x08 each one cycle after load, valid=1.
- Out-of-range decode: NUM_OUT=5 instance, SEL_W=3, load sel=6 -> out=0, valid=0, idx holds previous value; with DECODER_N_SCAN_ERR_EN, err=1 until err_clr pulse.
- Scan wrap:
  - NUM_OUT=5, div=2, mode=1 from idx=0: out steps 0x01,0x02,0x04,0x08,0x10,0x01, holding each for 3 cycles.
  - wrap=1 for exactly one cycle at 0x10 -> 0x01.
  - div=0 steps every cycle.
- Load during scan: scanning at idx=1 with prescaler mid-count, load sel=3 -> next cycle out=0x08, then held div+1 full cycles before advancing to 0x10; a simultaneous step is suppressed.
- Enable/blank: scanning at idx=2, en=0 for 4 cycles -> out=0, valid=0, idx=2 held. en=1 -> out=0x04 next cycle, prescaler restarted from 0.
- Mode switch: decode at sel=7 (NUM_OUT=8), switch to mode=1 with div=1 -> out=0x80, then after 2 cycles 0x01 with wrap pulse; switch back to mode=0 -> out holds last value, no further steps.
